decoder_scan: RTL and testbench

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_pkg.sv | 22 ++
 rtl/decoder_scan_onehot_dec.sv | 19 +
 rtl/decoder_scan.sv | 137 +++++++++++++
 tb/tb_decoder_scan.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings for the one-hot scan decoder: mode field values,
// FSM state encoding and the prescaler width helper.
package decoder_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_DIRECT = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_SWEEP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2,
    S_SWEEP  = 2'd3
  } state_t;

  // Dwell counter width: max(1, clog2(div)); div is expected in 1..256.
  function automatic int presc_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Pure combinational binary-to-one-hot decoder, one compare per output bit.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter  int IN_W  = 4,
  localparam int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  genvar i;
  generate
    for (i = 0; i < OUT_W; i++) begin : g_bit
      assign out[i] = (in == IN_W'(i));
    end
  endgenerate

endmodule

// File: rtl/decoder_scan.sv
// One-hot select generator: direct decode, continuous scan or single sweep
// over 2**IN_W positions, each position held for DIV clock cycles.
// Every output is registered from the next-state/next-position values, so
// the first cycle in a new state already shows that state's output.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int IN_W  = 4,
  parameter  int DIV   = 1,   // dwell per position, 1..256
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  in,
  input  logic             start,
  output logic [OUT_W-1:0] out,
  output logic [IN_W-1:0]  index,
  output logic             busy,
  output logic             done
);

  localparam int              PW         = presc_w(DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [IN_W-1:0] POS_LAST   = '1;

  state_t           state, nstate;
  logic [IN_W-1:0]  pos, npos;
  logic [PW-1:0]    presc, npresc;
  logic             dwell_end;
  logic             fin;
  logic [IN_W-1:0]  sel;
  logic [OUT_W-1:0] oh;
  logic [OUT_W-1:0] out_d;
  logic [IN_W-1:0]  index_d;
  logic             busy_d, done_d;

  assign dwell_end = (presc == PRESC_LAST);

  onehot_dec #(.IN_W(IN_W)) u_dec (
    .in  (sel),
    .out (oh)
  );

  // State, position, prescaler and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pos   <= '0;
      presc <= '0;
      out   <= '0;
      index <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      pos   <= npos;
      presc <= npresc;
      out   <= out_d;
      index <= index_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Next state plus next position/prescaler; enable=0 outranks start
  always_comb begin
    nstate = state;
    npos   = pos;
    npresc = presc;
    fin    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          case (mode)
            MODE_DIRECT: nstate = S_DIRECT;
            MODE_SCAN: if (start) begin
              nstate = S_SCAN;
              npos   = in;
              npresc = '0;
            end
            MODE_SWEEP: if (start) begin
              nstate = S_SWEEP;
              npos   = in;
              npresc = '0;
            end
            default: nstate = S_IDLE;
          endcase
        end
      end
      S_DIRECT: begin
        if (!enable || mode != MODE_DIRECT) nstate = S_IDLE;
      end
      S_SCAN: begin
        if (!enable || mode != MODE_SCAN) begin
          nstate = S_IDLE;
        end else if (dwell_end) begin
          npos   = pos + IN_W'(1);     // natural wrap at OUT_W-1
          npresc = '0;
        end else begin
          npresc = presc + PW'(1);
        end
      end
      S_SWEEP: begin
        if (!enable || mode != MODE_SWEEP) begin
          nstate = S_IDLE;             // abort: no done pulse
        end else if (dwell_end) begin
          npresc = '0;
          if (pos == POS_LAST) begin
            nstate = S_IDLE;
            fin    = 1'b1;
          end else begin
            npos = pos + IN_W'(1);
          end
        end else begin
          npresc = presc + PW'(1);
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Next output values, decoded from where the FSM is about to be
  always_comb begin
    sel     = (nstate == S_DIRECT) ? in : npos;
    out_d   = '0;
    index_d = '0;
    busy_d  = (nstate == S_SCAN) || (nstate == S_SWEEP);
    done_d  = fin;
    if (nstate != S_IDLE) begin
      out_d   = oh;
      index_d = sel;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: five instances (IN_W 4/DIV 1,2,3; IN_W 2
// and 6 with DIV 1) share control inputs; a selector picks which instance the
// expected-value queue is compared against.
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, enable, start;
  logic [1:0] mode;
  logic [3:0] in4;
  logic [1:0] in2;
  logic [5:0] in6;

  logic [15:0] o_a, o_b, o_c;
  logic [3:0]  i_a, i_b, i_c;
  logic        b_a, b_b, b_c, d_a, d_b, d_c;
  logic [3:0]  o_2;
  logic [1:0]  i_2;
  logic        b_2, d_2;
  logic [63:0] o_6;
  logic [5:0]  i_6;
  logic        b_6, d_6;

  decoder_scan #(.IN_W(4), .DIV(1)) u_a (.clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in(in4), .start(start), .out(o_a), .index(i_a), .busy(b_a), .done(d_a));
  decoder_scan #(.IN_W(4), .DIV(2)) u_b (.clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in(in4), .start(start), .out(o_b), .index(i_b), .busy(b_b), .done(d_b));
  decoder_scan #(.IN_W(4), .DIV(3)) u_c (.clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in(in4), .start(start), .out(o_c), .index(i_c), .busy(b_c), .done(d_c));
  decoder_scan #(.IN_W(2), .DIV(1)) u_2 (.clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in(in2), .start(start), .out(o_2), .index(i_2), .busy(b_2), .done(d_2));
  decoder_scan #(.IN_W(6), .DIV(1)) u_6 (.clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in(in6), .start(start), .out(o_6), .index(i_6), .busy(b_6), .done(d_6));

  int sel;
  logic [63:0] obs_out;
  logic [7:0]  obs_idx;
  logic        obs_busy, obs_done;

  always_comb begin
    obs_out = '0; obs_idx = '0; obs_busy = 1'b0; obs_done = 1'b0;
    case (sel)
      0: begin obs_out = 64'(o_a); obs_idx = 8'(i_a); obs_busy = b_a; obs_done = d_a; end
      1: begin obs_out = 64'(o_b); obs_idx = 8'(i_b); obs_busy = b_b; obs_done = d_b; end
      2: begin obs_out = 64'(o_c); obs_idx = 8'(i_c); obs_busy = b_c; obs_done = d_c; end
      3: begin obs_out = 64'(o_2); obs_idx = 8'(i_2); obs_busy = b_2; obs_done = d_2; end
      default: begin obs_out = o_6; obs_idx = 8'(i_6); obs_busy = b_6; obs_done = d_6; end
    endcase
  end

  typedef struct {
    string       tag;
    logic [63:0] out;
    logic [7:0]  idx;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int nchk  = 0;
  int npass = 0;

  // Out must be one-hot or zero on every instance, every cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      nchk += 5;
      assert ($onehot0(o_a)) npass++; else $error("FAIL onehot_a: out=%h required at most one bit", o_a);
      assert ($onehot0(o_b)) npass++; else $error("FAIL onehot_b: out=%h required at most one bit", o_b);
      assert ($onehot0(o_c)) npass++; else $error("FAIL onehot_c: out=%h required at most one bit", o_c);
      assert ($onehot0(o_2)) npass++; else $error("FAIL onehot_2: out=%h required at most one bit", o_2);
      assert ($onehot0(o_6)) npass++; else $error("FAIL onehot_6: out=%h required at most one bit", o_6);
    end
  end

  task automatic set_in(input int v);
    in4 = 4'(v); in2 = 2'(v); in6 = 6'(v);
  endtask

  task automatic compare();
    exp_t e;
    e = q.pop_front();
    nchk++;
    assert ({obs_out, obs_idx, obs_busy, obs_done} === {e.out, e.idx, e.busy, e.done}) npass++;
    else $error("FAIL %s (dut %0d): got out=%h idx=%0d busy=%b done=%b, want out=%h idx=%0d busy=%b done=%b",
                e.tag, sel, obs_out, obs_idx, obs_busy, obs_done, e.out, e.idx, e.busy, e.done);
  endtask

  // Expected result of the next rising edge, compared 1 time unit after it
  task automatic tick_chk(input string tag, input logic [63:0] eo, input int ei,
                          input logic eb, input logic ed);
    q.push_back('{tag, eo, 8'(ei), eb, ed});
    @(posedge clk); #1;
    compare();
  endtask

  task automatic check_now(input string tag);
    q.push_back('{tag, 64'd0, 8'd0, 1'b0, 1'b0});
    #1;
    compare();
  endtask

  task automatic idle_all();
    enable = 1'b0; mode = 2'b00; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_direct(input int s, input int w);
    sel = s; idle_all();
    enable = 1'b1; mode = 2'b01;
    for (int k = 0; k < (1 << w); k++) begin
      set_in(k);
      tick_chk("direct", 64'd1 << k, k, 1'b0, 1'b0);
    end
    enable = 1'b0;
    tick_chk("direct_off", 64'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic run_sweep(input int s, input int w, input int d, input int st);
    sel = s; idle_all();
    enable = 1'b1; mode = 2'b11; set_in(st); start = 1'b1;
    for (int p = st; p < (1 << w); p++)
      for (int r = 0; r < d; r++) begin
        tick_chk("sweep", 64'd1 << p, p, 1'b1, 1'b0);
        start = 1'b0;
      end
    tick_chk("sweep_done", 64'd0, 0, 1'b0, 1'b1);
    tick_chk("sweep_idle", 64'd0, 0, 1'b0, 1'b0);
  endtask

  // Scan with a stray start (and a different in) pulsed mid-run
  task automatic run_scan(input int s, input int w, input int d, input int st, input int n);
    int p;
    sel = s; idle_all();
    enable = 1'b1; mode = 2'b10; set_in(st); start = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == 2) begin start = 1'b1; set_in(0); end
      p = (st + i / d) % (1 << w);
      tick_chk("scan", 64'd1 << p, p, 1'b1, 1'b0);
      start = 1'b0;
    end
  endtask

  initial begin
    sel = 0; rst_n = 1'b0; enable = 1'b0; mode = 2'b00; start = 1'b0; set_in(0);
    #12;
    for (int s = 0; s < 5; s++) begin
      sel = s;
      check_now("reset");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Direct decode on every width
    run_direct(0, 4);
    run_direct(3, 2);
    run_direct(4, 6);

    // Sweeps: mid start, last-position start, other widths
    run_sweep(1, 4, 2, 13);
    run_sweep(1, 4, 2, 15);
    run_sweep(3, 2, 1, 1);
    run_sweep(4, 6, 1, 60);

    // Scan wrap
    run_scan(0, 4, 1, 14, 4);
    run_scan(1, 4, 2, 15, 5);
    run_scan(3, 2, 1, 2, 6);
    run_scan(4, 6, 1, 62, 4);

    // enable=0 wins over start
    sel = 0; idle_all();
    enable = 1'b0; mode = 2'b10; set_in(3); start = 1'b1;
    tick_chk("en_low_start", 64'd0, 0, 1'b0, 1'b0);
    start = 1'b0;

    // Start in mode 00 is ignored
    enable = 1'b1; mode = 2'b00; start = 1'b1;
    tick_chk("mode_off_start", 64'd0, 0, 1'b0, 1'b0);
    start = 1'b0;

    // Abort a DIV=3 sweep from 0 at position 5
    sel = 2; idle_all();
    enable = 1'b1; mode = 2'b11; set_in(0); start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick_chk("abort_run", 64'd1 << (i / 3), i / 3, 1'b1, 1'b0);
      start = 1'b0;
    end
    enable = 1'b0;
    tick_chk("abort", 64'd0, 0, 1'b0, 1'b0);
    tick_chk("abort_nodone", 64'd0, 0, 1'b0, 1'b0);
    enable = 1'b1;
    tick_chk("abort_idle", 64'd0, 0, 1'b0, 1'b0);

    // Reset mid-sweep, then relaunch on the first edge after release
    sel = 1; idle_all();
    enable = 1'b1; mode = 2'b11; set_in(2); start = 1'b1;
    tick_chk("pre_rst", 64'd1 << 2, 2, 1'b1, 1'b0);
    start = 1'b0;
    tick_chk("pre_rst", 64'd1 << 2, 2, 1'b1, 1'b0);
    tick_chk("pre_rst", 64'd1 << 3, 3, 1'b1, 1'b0);
    rst_n = 1'b0;
    check_now("rst_async");
    tick_chk("rst_hold", 64'd0, 0, 1'b0, 1'b0);
    rst_n = 1'b1; start = 1'b1;
    tick_chk("rst_relaunch", 64'd1 << 2, 2, 1'b1, 1'b0);
    start = 1'b0;
    tick_chk("rst_relaunch", 64'd1 << 2, 2, 1'b1, 1'b0);
    tick_chk("rst_relaunch", 64'd1 << 3, 3, 1'b1, 1'b0);
    idle_all();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
